// File: rtl/prog_mem_rw.sv
// Writable program memory for the uProcessor.
// A load port writes instructions at run time. A registered fetch port returns
// the addressed word with a valid flag. A clear sequencer fills every word with
// NOP after reset and whenever clr is requested.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                request a full NOP sweep
//   ld_en/ld_addr/ld_data   write strobe, address, data
//   ld_err             1-cycle pulse: the previous cycle's load was rejected
//   fetch_en/fetch_addr     fetch strobe and address
//   ins_out/ins_valid  registered fetched word and its valid flag
//   busy               clear sweep in progress
module prog_mem_rw #(
    parameter int unsigned       OPC_W      = 4,
    parameter int unsigned       REG_W      = 2,
    parameter int unsigned       INS_W      = OPC_W + REG_W,
    parameter int unsigned       ADDR_W     = 5,
    parameter int unsigned       DEPTH      = 32,
    parameter logic [OPC_W-1:0]  OPCODE_NOP = '0,
    parameter logic [INS_W-1:0]  NOP_WORD   = {OPCODE_NOP, REG_W'(0)}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [INS_W-1:0]  ld_data,
    output logic              ld_err,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [INS_W-1:0]  ins_out,
    output logic              ins_valid,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, cnt_nxt;
    logic [INS_W-1:0]  ins_nxt;
    logic              valid_nxt;
    logic              err_nxt;
    logic              busy_nxt;

    logic              mem_we_c;
    logic [IDX_W-1:0]  mem_waddr_c;
    logic [INS_W-1:0]  mem_wdata_c;
    logic [INS_W-1:0]  rd_word_c;
    logic              ld_in_range_c;
    logic              fetch_in_range_c;

    logic [INS_W-1:0]  mem [DEPTH];

    assign ld_in_range_c    = {1'b0, ld_addr} < DEPTH_X;
    assign fetch_in_range_c = {1'b0, fetch_addr} < DEPTH_X;

    // Storage array; not reset, the sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            busy      <= 1'b1;
            ins_out   <= NOP_WORD;
            ins_valid <= 1'b0;
            ld_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= cnt_nxt;
            busy      <= busy_nxt;
            ins_out   <= ins_nxt;
            ins_valid <= valid_nxt;
            ld_err    <= err_nxt;
        end
    end

    // Next-state, memory write port and registered-output logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = clr_cnt;
        ins_nxt     = ins_out;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = '0;
        mem_wdata_c = NOP_WORD;
        // Combinational read of the current array gives read-first behaviour
        // when a load targets the same address in the same cycle.
        rd_word_c   = NOP_WORD;
        if (fetch_in_range_c) begin
            rd_word_c = mem[IDX_W'(fetch_addr)];
        end

        case (state)
            ST_CLEAR: begin
                err_nxt = ld_en;
                if (clr) begin
                    cnt_nxt = '0;
                end else begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = IDX_W'(clr_cnt);
                    cnt_nxt     = clr_cnt + ADDR_W'(1);
                    if (clr_cnt == LAST_ADDR) begin
                        state_nxt = ST_READY;
                    end
                end
            end
            default: begin
                if (clr) begin
                    // clr wins over any load or fetch in the same cycle.
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                    err_nxt   = ld_en;
                end else begin
                    if (ld_en) begin
                        if (ld_in_range_c) begin
                            mem_we_c    = 1'b1;
                            mem_waddr_c = IDX_W'(ld_addr);
                            mem_wdata_c = ld_data;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                    if (fetch_en) begin
                        ins_nxt   = rd_word_c;
                        valid_nxt = 1'b1;
                    end
                end
            end
        endcase

        busy_nxt = (state_nxt == ST_CLEAR);
    end

endmodule

// File: tb/tb_prog_mem_rw.sv
// Self-checking bench for prog_mem_rw: a default (DEPTH=32) instance and a
// DEPTH=20 instance share all inputs.
module tb_prog_mem_rw;

    localparam logic [5:0] NOP = 6'b000000;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       ld_en;
    logic [4:0] ld_addr;
    logic [5:0] ld_data;
    logic       fetch_en;
    logic [4:0] fetch_addr;

    logic       ld_err, ins_valid, busy;
    logic [5:0] ins_out;
    logic       ld_err20, ins_valid20, busy20;
    logic [5:0] ins_out20;

    int pass_cnt = 0;
    int total_cnt = 0;

    prog_mem_rw dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .ins_out(ins_out), .ins_valid(ins_valid), .busy(busy)
    );

    prog_mem_rw #(.DEPTH(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err20),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .ins_out(ins_out20), .ins_valid(ins_valid20), .busy(busy20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld_en;
        logic [4:0] ld_addr;
        logic [5:0] ld_data;
        logic       fetch_en;
        logic [4:0] fetch_addr;
        logic [5:0] exp_ins;
        logic       exp_valid;
        logic       exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Counts cycles with busy=1 starting at the current sample; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic fetch_all_nop(input string tag);
        for (int a = 0; a < 32; a++) begin
            fetch_en   = 1'b1;
            fetch_addr = 5'(a);
            step();
            chk({tag, "_ins"}, 32'(ins_out), 32'(NOP));
            chk({tag, "_valid"}, 32'(ins_valid), 32'd1);
        end
        fetch_en = 1'b0;
    endtask

    initial begin
        int n;

        //            ld  addr   data       fe  faddr  exp_ins    v     err
        vecs[0]  = '{1'b1, 5'd0, 6'b000101, 1'b0, 5'd0, NOP,       1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd1, 6'b001001, 1'b0, 5'd0, NOP,       1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd4, 6'b000111, 1'b0, 5'd0, NOP,       1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 6'b000000, 1'b1, 5'd0, 6'b000101, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 6'b000000, 1'b1, 5'd1, 6'b001001, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 6'b000000, 1'b1, 5'd2, NOP,       1'b1, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 6'b000000, 1'b1, 5'd3, NOP,       1'b1, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 6'b000000, 1'b1, 5'd4, 6'b000111, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 5'd7, 6'b001110, 1'b1, 5'd7, NOP,       1'b1, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 6'b000000, 1'b1, 5'd7, 6'b001110, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 6'b000000, 1'b0, 5'd7, 6'b001110, 1'b0, 1'b0};

        rst_n = 1'b0; clr = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        fetch_en = 1'b0; fetch_addr = '0;

        // Reset values.
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ins", 32'(ins_out), 32'(NOP));
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_err", 32'(ld_err), 32'd0);
        chk("rst_busy20", 32'(busy20), 32'd1);

        // Initial sweep length, then every word reads NOP.
        rst_n = 1'b1;
        count_busy(n);
        chk("sweep_len", 32'(n), 32'd32);
        chk("busy20_done", 32'(busy20), 32'd0);
        fetch_all_nop("init");

        // Loads, back-to-back fetches, read-first collision.
        for (int i = 0; i < 11; i++) begin
            ld_en      = vecs[i].ld_en;
            ld_addr    = vecs[i].ld_addr;
            ld_data    = vecs[i].ld_data;
            fetch_en   = vecs[i].fetch_en;
            fetch_addr = vecs[i].fetch_addr;
            step();
            chk($sformatf("vec%0d_ins", i), 32'(ins_out), 32'(vecs[i].exp_ins));
            chk($sformatf("vec%0d_valid", i), 32'(ins_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_err", i), 32'(ld_err), 32'(vecs[i].exp_err));
        end
        ld_en = 1'b0; fetch_en = 1'b0;

        // Address 25: in range for DEPTH=32, out of range for DEPTH=20.
        ld_en = 1'b1; ld_addr = 5'd25; ld_data = 6'b010101;
        step();
        chk("oor_err20", 32'(ld_err20), 32'd1);
        chk("oor_err32", 32'(ld_err), 32'd0);
        ld_en = 1'b0; fetch_en = 1'b1; fetch_addr = 5'd25;
        step();
        chk("oor_err20_drop", 32'(ld_err20), 32'd0);
        chk("oor_ins20", 32'(ins_out20), 32'(NOP));
        chk("oor_valid20", 32'(ins_valid20), 32'd1);
        chk("oor_ins32", 32'(ins_out), 32'(6'b010101));
        fetch_en = 1'b0;

        // Load addr 2 and fetch it so ins_out holds a non-NOP word.
        ld_en = 1'b1; ld_addr = 5'd2; ld_data = 6'b101010;
        step();
        ld_en = 1'b0; fetch_en = 1'b1; fetch_addr = 5'd2;
        step();
        chk("pre_clr_ins", 32'(ins_out), 32'(6'b101010));

        // clr with a load in the same cycle: clr wins, load rejected.
        clr = 1'b1; ld_en = 1'b1; ld_addr = 5'd5; ld_data = 6'b110011;
        step();
        clr = 1'b0;
        chk("clr_ld_err", 32'(ld_err), 32'd1);
        chk("clr_valid", 32'(ins_valid), 32'd0);
        n = busy ? 1 : 0;
        // Loads and fetches during the sweep are rejected.
        ld_addr = 5'd3; ld_data = 6'b111111; fetch_addr = 5'd0;
        for (int j = 1; j <= 9; j++) begin
            step();
            if (busy) n++;
            chk("sweep_ld_err", 32'(ld_err), 32'd1);
            chk("sweep_valid", 32'(ins_valid), 32'd0);
            chk("sweep_ins_hold", 32'(ins_out), 32'(6'b101010));
        end
        // Restart the sweep 10 cycles in.
        clr = 1'b1;
        step();
        clr = 1'b0;
        if (busy) n++;
        chk("restart_err", 32'(ld_err), 32'd1);
        ld_en = 1'b0; fetch_en = 1'b0;
        while (busy && n < 200) begin
            step();
            if (busy) n++;
        end
        chk("restart_len", 32'(n), 32'd42);
        fetch_all_nop("post_clr");

        // Mid-sweep asynchronous reset.
        ld_en = 1'b1; ld_addr = 5'd2; ld_data = 6'b101010;
        step();
        ld_en = 1'b0; fetch_en = 1'b1; fetch_addr = 5'd2;
        step();
        chk("pre_rst_ins", 32'(ins_out), 32'(6'b101010));
        fetch_en = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        ld_en = 1'b1; ld_addr = 5'd9; fetch_en = 1'b1;
        for (int j = 0; j < 15; j++) step();
        chk("pre_rst_err", 32'(ld_err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_ins", 32'(ins_out), 32'(NOP));
        chk("arst_valid", 32'(ins_valid), 32'd0);
        chk("arst_err", 32'(ld_err), 32'd0);
        ld_en = 1'b0; fetch_en = 1'b0;
        step();
        rst_n = 1'b1;
        count_busy(n);
        chk("arst_sweep_len", 32'(n), 32'd32);
        fetch_en = 1'b1; fetch_addr = 5'd2;
        step();
        chk("arst_addr2_ins", 32'(ins_out), 32'(NOP));
        chk("arst_addr2_valid", 32'(ins_valid), 32'd1);
        fetch_en = 1'b0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/prog_mem_rw.md
Name: prog_mem_rw

Overview:
Parametrised, writable program memory for the uProcessor. It replaces the fixed initial-block ROM with a clocked store that has three parts: a load port for writing instructions at run time, a registered fetch port with a valid flag, and a hardware clear sequencer. The clear sequencer fills every location with NOP after reset and on request. It sits between the program counter (fetch_addr) and the instruction decoder (ins_out).

Parameters:
OPC_W, 4, opcode field width
REG_W, 2, register-select field width
INS_W, OPC_W+REG_W, instruction word width
ADDR_W, 5, address width
DEPTH, 32, number of implemented words; DEPTH <= 2**ADDR_W and DEPTH >= 2
NOP_WORD, {`OPCODE_NOP, REG_W'b0}, fill and default word

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  request a full NOP sweep (sampled level; a 1-cycle pulse is sufficient)
ld_en  in  1  write strobe
ld_addr  in  ADDR_W  write address
ld_data  in  INS_W  write data
ld_err  out  1  1-cycle pulse: the load in the previous cycle was rejected
fetch_en  in  1  fetch strobe
fetch_addr  in  ADDR_W  fetch address
ins_out  out  INS_W  fetched instruction (registered)
ins_valid  out  1  ins_out was updated by a fetch in the previous cycle
busy  out  1  clear sweep in progress

Behaviour:
- Reset (rst_n=0, asynchronous): state=CLEAR, clr_cnt=0, busy=1, ins_out=NOP_WORD, ins_valid=0, ld_err=0. The array itself is not reset; the sweep initialises it.
- FSM, two states:
  - CLEAR: each cycle Mem[clr_cnt] <= NOP_WORD and clr_cnt increments. After writing DEPTH-1, go to READY. The sweep takes exactly DEPTH cycles after rst_n rises.
  - READY: normal operation. clr=1 -> CLEAR with clr_cnt=0.
- busy = (state==CLEAR), registered.
- clr asserted while in CLEAR restarts the sweep at clr_cnt=0.
- Load, READY only: with ld_en=1 and ld_addr<DEPTH, Mem[ld_addr] <= ld_data at the edge.
  - ld_addr >= DEPTH: no write, ld_err=1 next cycle.
  - ld_en=1 while busy: no write, ld_err=1 next cycle.
  - ld_en=1 with clr=1 in the same cycle: clr wins, no write, ld_err=1.
- Fetch, READY only: fetch_en=1 -> ins_out <= Mem[fetch_addr] and ins_valid <= 1 on the next edge (1-cycle latency).
  - fetch_addr >= DEPTH: ins_out <= NOP_WORD, ins_valid <= 1.
  - fetch_en=0: ins_valid <= 0, ins_out holds its value.
  - fetch_en=1 while busy or with clr=1: ins_valid <= 0, ins_out holds.
- Load and fetch to the same address in the same cycle: read-first, so ins_out gets the old word. The new word is visible on the next fetch.
- Back-to-back fetches every cycle give one valid word per cycle (full throughput).
- rst_n asserted mid-sweep or mid-operation aborts everything immediately and the sweep restarts from 0 after release.
- ld_err is never asserted for a cycle with ld_en=0.

Test Plan:
- Reset release -> busy=1 for exactly 32 cycles, then 0. Fetch each of addr 0..31 -> every ins_out=NOP_WORD with ins_valid=1, one cycle after each request.
- In READY, load addr0=6'b0001_01, addr1=6'b0010_01, addr4=6'b0001_11. Fetch 0,1,2,3,4 back-to-back -> ins_out 000101, 001001, NOP, NOP, 000111 on consecutive cycles, ins_valid held at 1.
- Same cycle: ld_en=1 and fetch_en=1, both to addr 7. Old word NOP, new word 6'b0011_10 -> ins_out=NOP. Fetch addr 7 again -> 001110.
- DEPTH=20 build: load addr 25 -> ld_err pulse, no write. Fetch addr 25 -> NOP_WORD with ins_valid=1.
- After loading data, pulse clr. Pulse clr again 10 cycles into the sweep -> busy lasts 10+32 cycles total. Loads and fetches during the sweep -> ld_err=1 and ins_valid=0. All words read as NOP afterwards.
- Drop rst_n for 1 cycle mid-sweep (clr_cnt=15) -> outputs at reset values immediately. Full 32-cycle sweep after release.
